// File: rtl/ex_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage; owns HI/LO and stalls dependent ops.
// Define MULDIV_FAST_MULT_EN to replace the 32-cycle shift-add multiply with a single-cycle multiplier.
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            opcode_in,
    input  logic [5:0]            function_in,
    input  logic [DATA_WIDTH-1:0] operand_a_in,
    input  logic [DATA_WIDTH-1:0] operand_b_in,
    input  logic                  flush_in,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out,
    output logic [DATA_WIDTH-1:0] mf_result_out,
    output logic                  mf_valid_out,
    output logic                  busy_out,
    output logic                  stall_out
);

    localparam int DW = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DW - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [DW-1:0]        hi_q, lo_q;
    logic                 busy_q;
    logic [DW-1:0]        acc_q, shf_q, opd_q, raw_a_q;
    logic                 is_div_q, neg_q, rneg_q, div0_q;

    logic is_r, is_mfhi, is_mthi, is_mflo, is_mtlo;
    logic is_mult, is_multu, is_div, is_divu, is_start, is_any, is_signed;
    logic [DW-1:0]   mag_a, mag_b;
    logic [DW:0]     mul_sum;
    logic [DW:0]     div_rsh;
    logic            div_ok;
    logic [2*DW-1:0] prod, prod_fix;
    logic [DW-1:0]   quo_fix, rem_fix;

    always_comb begin
        is_r      = (opcode_in == 6'h00);
        is_mfhi   = is_r && (function_in == 6'h10);
        is_mthi   = is_r && (function_in == 6'h11);
        is_mflo   = is_r && (function_in == 6'h12);
        is_mtlo   = is_r && (function_in == 6'h13);
        is_mult   = is_r && (function_in == 6'h18);
        is_multu  = is_r && (function_in == 6'h19);
        is_div    = is_r && (function_in == 6'h1A);
        is_divu   = is_r && (function_in == 6'h1B);
        is_start  = is_mult | is_multu | is_div | is_divu;
        is_any    = is_start | is_mfhi | is_mthi | is_mflo | is_mtlo;
        is_signed = is_mult | is_div;
        mag_a     = (is_signed && operand_a_in[DW-1]) ? -operand_a_in : operand_a_in;
        mag_b     = (is_signed && operand_b_in[DW-1]) ? -operand_b_in : operand_b_in;
    end

    // Shift-add keeps the running high half in acc_q and shifts product bits into shf_q
    // as the multiplier bits are consumed; restoring division reuses the same pair.
    always_comb begin
        mul_sum  = {1'b0, acc_q} + (shf_q[0] ? {1'b0, opd_q} : '0);
        div_rsh  = {acc_q, shf_q[DW-1]};
        div_ok   = (div_rsh >= {1'b0, opd_q});
        prod     = {acc_q, shf_q};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -shf_q : shf_q;
        rem_fix  = rneg_q ? -acc_q : acc_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            acc_q    <= '0;
            shf_q    <= '0;
            opd_q    <= '0;
            raw_a_q  <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!flush_in) begin
                        if (is_mthi) hi_q <= operand_a_in;
                        if (is_mtlo) lo_q <= operand_a_in;
                        if (is_start) begin
                            is_div_q <= is_div | is_divu;
                            neg_q    <= is_signed & (operand_a_in[DW-1] ^ operand_b_in[DW-1]);
                            rneg_q   <= is_signed & operand_a_in[DW-1];
                            raw_a_q  <= operand_a_in;
                            div0_q   <= (operand_b_in == '0);
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            if (is_div | is_divu) begin
                                acc_q   <= '0;
                                shf_q   <= mag_a;
                                opd_q   <= mag_b;
                                state_q <= DIV;
                            end else begin
`ifdef MULDIV_FAST_MULT_EN
                                {acc_q, shf_q} <= {{DW{1'b0}}, mag_a} * {{DW{1'b0}}, mag_b};
                                state_q        <= FIX;
`else
                                acc_q   <= '0;
                                shf_q   <= mag_b;
                                opd_q   <= mag_a;
                                state_q <= MUL;
`endif
                            end
                        end
                    end
                end
                MUL: begin
                    acc_q <= mul_sum[DW:1];
                    shf_q <= {mul_sum[0], shf_q[DW-1:1]};
                    if (cnt_q == LAST_ITER) begin
                        cnt_q   <= '0;
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DIV: begin
                    acc_q <= div_ok ? (div_rsh[DW-1:0] - opd_q) : div_rsh[DW-1:0];
                    shf_q <= {shf_q[DW-2:0], div_ok};
                    if (cnt_q == LAST_ITER) begin
                        cnt_q   <= '0;
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FIX: begin
                    if (!is_div_q) begin
                        hi_q <= prod_fix[2*DW-1:DW];
                        lo_q <= prod_fix[DW-1:0];
                    end else if (div0_q) begin
                        hi_q <= raw_a_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        hi_out        = hi_q;
        lo_out        = lo_q;
        busy_out      = busy_q;
        stall_out     = busy_q & is_any & ~flush_in;
        mf_valid_out  = (is_mfhi | is_mflo) & ~stall_out & ~flush_in;
        mf_result_out = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: vector table of mult/div results plus hand-built stall,
// flush and reset sequences.
module tb_ex_muldiv_unit;

    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode_in, function_in;
    logic [31:0] operand_a_in, operand_b_in;
    logic        flush_in;
    logic [31:0] hi_out, lo_out, mf_result_out;
    logic        mf_valid_out, busy_out, stall_out;

    int n_chk  = 0;
    int n_fail = 0;

    ex_muldiv_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode_in    (opcode_in),
        .function_in  (function_in),
        .operand_a_in (operand_a_in),
        .operand_b_in (operand_b_in),
        .flush_in     (flush_in),
        .hi_out       (hi_out),
        .lo_out       (lo_out),
        .mf_result_out(mf_result_out),
        .mf_valid_out (mf_valid_out),
        .busy_out     (busy_out),
        .stall_out    (stall_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        opcode_in    = 6'h00;
        function_in  = fn;
        operand_a_in = a;
        operand_b_in = b;
        flush_in     = fl;
    endtask

    task automatic nop();
        opcode_in    = 6'h08;
        function_in  = 6'h00;
        operand_a_in = '0;
        operand_b_in = '0;
        flush_in     = 1'b0;
    endtask

    // Called at the first negedge after the accepting edge; counts busy cycles.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy_out && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        int lat;

        vecs[0]  = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{F_DIVU,  32'h00000009, 32'h00000000, 32'h00000009, 32'hFFFFFFFF};
        vecs[5]  = '{F_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6]  = '{F_MULTU, 32'h12345678, 32'h00000009, 32'h00000000, 32'hA3D70A38};
        vecs[7]  = '{F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[8]  = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{F_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

        reset = 1'b0;
        nop();
        repeat (3) @(negedge clk);
        chk("reset_hi", hi_out, 32'h0);
        chk("reset_lo", lo_out, 32'h0);
        chk("reset_busy", {31'b0, busy_out}, 32'h0);
        chk("reset_stall", {31'b0, stall_out}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // MTHI then MFHI readback
        drive(F_MTHI, 32'h0000CAFE, 32'h0, 1'b0);
        @(negedge clk);
        drive(F_MFHI, 32'h0, 32'h0, 1'b0);
        #1;
        chk("mfhi_valid", {31'b0, mf_valid_out}, 32'h1);
        chk("mfhi_result", mf_result_out, 32'h0000CAFE);
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].fn, vecs[i].a, vecs[i].b, 1'b0);
            @(negedge clk);
            nop();
            wait_idle(cyc);
            lat = (vecs[i].fn == F_MULT || vecs[i].fn == F_MULTU) ? MUL_LAT : DIV_LAT;
            chk($sformatf("vec%0d_latency", i), cyc, lat);
            chk($sformatf("vec%0d_hi", i), hi_out, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), lo_out, vecs[i].lo);
            drive(F_MFLO, 32'h0, 32'h0, 1'b0);
            #1;
            chk($sformatf("vec%0d_mflo", i), mf_result_out, vecs[i].lo);
            @(negedge clk);
            nop();
            @(negedge clk);
        end

        // MULT followed by dependent MFLO: stalled until the result lands
        drive(F_MULT, 32'd3, 32'd5, 1'b0);
        @(negedge clk);
        drive(F_MFLO, 32'h0, 32'h0, 1'b0);
        cyc = 0;
        while (stall_out && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        chk("dep_stall_cycles", cyc, MUL_LAT);
        chk("dep_mf_valid", {31'b0, mf_valid_out}, 32'h1);
        chk("dep_mf_result", mf_result_out, 32'd15);
        nop();
        @(negedge clk);

        // Second muldiv op while busy is held, then issues once the first completes
        drive(F_MULTU, 32'd2, 32'd3, 1'b0);
        @(negedge clk);
        drive(F_DIVU, 32'd20, 32'd6, 1'b0);
        #1;
        chk("div_busy_stall", {31'b0, stall_out}, 32'h1);
        cyc = 0;
        while (stall_out && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        chk("div_wait_cycles", cyc, MUL_LAT);
        chk("first_mul_lo", lo_out, 32'd6);
        @(negedge clk);
        nop();
        chk("second_div_accepted", {31'b0, busy_out}, 32'h1);
        wait_idle(cyc);
        chk("second_div_lo", lo_out, 32'd3);
        chk("second_div_hi", hi_out, 32'd2);

        // Flushed MULT and MTLO have no effect
        drive(F_MTLO, 32'h5555AAAA, 32'h0, 1'b0);
        @(negedge clk);
        drive(F_MULT, 32'd4, 32'd4, 1'b1);
        @(negedge clk);
        nop();
        chk("flush_mult_busy", {31'b0, busy_out}, 32'h0);
        chk("flush_mult_lo", lo_out, 32'h5555AAAA);
        chk("flush_mult_hi", hi_out, 32'd2);
        drive(F_MTLO, 32'h12121212, 32'h0, 1'b1);
        @(negedge clk);
        nop();
        chk("flush_mtlo_lo", lo_out, 32'h5555AAAA);

        // Flush while in flight: no stall, op still completes
        drive(F_DIVU, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        drive(F_MFLO, 32'h0, 32'h0, 1'b1);
        #1;
        chk("flush_inflight_stall", {31'b0, stall_out}, 32'h0);
        chk("flush_inflight_mfvalid", {31'b0, mf_valid_out}, 32'h0);
        @(negedge clk);
        nop();
        wait_idle(cyc);
        chk("flush_inflight_lo", lo_out, 32'd14);

        // Reset in the middle of a DIV aborts it
        drive(F_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        @(negedge clk);
        nop();
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midreset_busy", {31'b0, busy_out}, 32'h0);
        chk("midreset_hi", hi_out, 32'h0);
        chk("midreset_lo", lo_out, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(F_MTHI, 32'h00001234, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        chk("post_reset_mthi", hi_out, 32'h00001234);
        chk("post_reset_lo", lo_out, 32'h0);
        @(negedge clk);
        nop();
        @(negedge clk);
        chk("post_reset_busy", {31'b0, busy_out}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
